laser_tick_player: RTL and testbench
====================================

Name: laser_tick_player

Overview:
- Consumer side of the dt-tick write interface: holds ping-pong per-frame tick memories that the synchronizer fills (waddr/wdata/we/mem_select).
- On each mirror zero crossing, replays one line of stored dt ticks as timed laser trigger pulses.
- Toggles update_mem_o whenever it swaps to a freshly written bank, which tells the writer to refill the other bank.

Parameters:
FRAME_COLUMNS_P, 360, dt entries (points) per line per frame
FRAME_LINES_P, 100, lines played per frame before advancing frame
FRAME_NUMBER_P, 5, frames per bank
MEM_CYCLES_P, 13, full passes over a bank before a swap is allowed
PULSE_LENGTH_P, 5, laser pulse width in clk cycles

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
zc_i  in  1  mirror zero-crossing, asynchronous to clk_i
waddr_i  in  11  column address of write
wdata_i  in  17  {active_pixel[16], dt_ticks[15:0]}
we_i  in  1  write strobe
mem_select_i  in  3  frame index of write
bank_done_i  in  1  one-cycle pulse: writer finished filling shadow bank
quarter_delay_i  in  16  clk cycles from zero crossing to line start
laser_trigger_o  out  1  laser pulse
update_mem_o  out  1  toggles on every bank swap
line_completed_o  out  1  one-cycle pulse when the last point of a line is fired
overrun_o  out  1  one-cycle pulse when zc arrives mid-line

Behaviour:
- Reset: all outputs 0; active_bank=0; shadow_valid=0; frame/line/col/cycle counters 0; state IDLE. Reset mid-line drops laser_trigger_o on the next edge. Memory contents are not cleared.
- Storage: two banks of FRAME_NUMBER_P*FRAME_COLUMNS_P x 17 bits. Flat index = mem_select_i*FRAME_COLUMNS_P + waddr_i.
- Writes always target the shadow bank (~active_bank). Writes with waddr_i >= FRAME_COLUMNS_P or mem_select_i >= FRAME_NUMBER_P are dropped.
- Memory reads are synchronous with 1-cycle latency.
- bank_done_i sets shadow_valid. A repeat bank_done_i while shadow_valid is already set has no effect.
- zc_i passes through a 2-FF synchronizer. A zc event is a rising edge on the synchronized signal, giving 3 clk cycles of latency from the zc_i edge.
- States:
  - IDLE: leave when shadow_valid=1. Swap banks, toggle update_mem_o, clear shadow_valid, go to WAIT_ZC.
  - WAIT_ZC: on a zc event, load delay counter = quarter_delay_i and go to DELAY. Prefetch entry (frame, col=0) during this state.
  - DELAY: count down to 0, then go to PLAY. quarter_delay_i=0 means PLAY is entered the cycle after the zc event.
  - PLAY: load countdown = max(dt,2); the prefetch of the next entry is issued at load.
    - When countdown reaches 1, fire: if active bit=1, laser_trigger_o high for PULSE_LENGTH_P cycles. A fire during an active pulse restarts the width counter (no gap).
    - col increments after each fire. After col=FRAME_COLUMNS_P-1 fires: line_completed_o pulses, col=0, line++, go to LINE_END.
  - LINE_END: apply the wrap rules below, then go to WAIT_ZC.
- Spacing: the first fire of a line occurs max(dt0,2) cycles after DELAY ends. Consecutive fires are spaced exactly max(dt,2) cycles.
- Wrap rules:
  - line == FRAME_LINES_P: line=0, frame++.
  - frame == FRAME_NUMBER_P: frame=0, cycle++.
  - cycle == MEM_CYCLES_P: cycle=0. If shadow_valid, swap (toggle update_mem_o, clear shadow_valid). Otherwise keep replaying the current bank.
- zc event during DELAY or PLAY:
  - overrun_o pulses and the current line is abandoned.
  - Line counters advance as if the line completed, but line_completed_o does not pulse.
  - Delay reloads and DELAY restarts.
  - Laser pulses in progress complete normally.
- bank_done_i coinciding with a swap cycle: the swap consumes the old flag and the new pulse sets shadow_valid again.
- Writes in the swap cycle land in the bank that becomes active. The writer must not write between bank_done_i and seeing update_mem_o toggle.

Optional Feature:
LASER_TICK_PLAYER_STATS_EN
- With the macro: adds output pulses_fired_o (32 bits), which counts laser pulse starts (retriggers included). Reset 0; cleared on every bank swap; saturates at all-ones.
- Without the macro: port and counter absent; all other behaviour identical.

Test Plan:
All scenarios use COLUMNS=4, LINES=2, FRAMES=2, MEM_CYCLES=1, PULSE=3.
- Fill shadow with dt=10 for all entries, active=1, then pulse bank_done_i -> update_mem_o goes 0->1 within 2 cycles; no pulses before the first zc.
- Set quarter_delay_i=20 and raise zc_i -> first laser_trigger_o rise 3+20+10 cycles after the zc_i edge (±1). Next rises every 10 cycles, 4 pulses each 3 cycles wide, and line_completed_o pulses with the 4th fire.
- Entry dt=1, next dt=0 -> fires spaced 2 cycles; pulse width counter retriggers so laser_trigger_o stays high continuously.
- Entry with active bit=0 -> no pulse at that slot and the following slot timing is unchanged.
- Second zc arriving 15 cycles into a line -> overrun_o single pulse; new line starts quarter_delay_i after the resync; line_completed_o does not pulse for the aborted line.
- After 4 lines (2 frames x 2 lines) with a new bank_done_i given mid-play -> update_mem_o toggles at the LINE_END of line 4 and the 5th line plays the new bank's data. Without bank_done_i, the old bank replays and update_mem_o is unchanged.

Source files
------------

// File: rtl/laser_tick_player.sv
// rtl/laser_tick_player.sv - ping-pong dt-tick memory replayed as timed laser pulses per mirror zero crossing
// Optional LASER_TICK_PLAYER_STATS_EN adds pulses_fired_o, a saturating count of pulse starts per bank.
module laser_tick_player #(
  parameter int FRAME_COLUMNS_P = 360,
  parameter int FRAME_LINES_P   = 100,
  parameter int FRAME_NUMBER_P  = 5,
  parameter int MEM_CYCLES_P    = 13,
  parameter int PULSE_LENGTH_P  = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        zc_i,
  input  logic [10:0] waddr_i,
  input  logic [16:0] wdata_i,
  input  logic        we_i,
  input  logic [2:0]  mem_select_i,
  input  logic        bank_done_i,
  input  logic [15:0] quarter_delay_i,
  output logic        laser_trigger_o,
  output logic        update_mem_o,
  output logic        line_completed_o,
  output logic        overrun_o
`ifdef LASER_TICK_PLAYER_STATS_EN
  ,
  output logic [31:0] pulses_fired_o
`endif
);

  localparam int DEPTH = FRAME_NUMBER_P * FRAME_COLUMNS_P;
  localparam int AW    = $clog2(2 * DEPTH);
  localparam int CW    = $clog2(FRAME_COLUMNS_P + 1);
  localparam int LW    = $clog2(FRAME_LINES_P + 1);
  localparam int FW    = $clog2(FRAME_NUMBER_P + 1);
  localparam int MW    = $clog2(MEM_CYCLES_P + 1);
  localparam int PW    = $clog2(PULSE_LENGTH_P + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ZC  = 3'd1,
    DELAY    = 3'd2,
    PLAY     = 3'd3,
    LINE_END = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          zc_meta_q, zc_meta_d, zc_sync_q, zc_sync_d, zc_prev_q, zc_prev_d;
  logic          active_bank_q, active_bank_d;
  logic          shadow_valid_q, shadow_valid_d;
  logic          update_mem_q, update_mem_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [MW-1:0] cycle_q, cycle_d;
  logic [15:0]   delay_q, delay_d;
  logic [15:0]   tick_q, tick_d;
  logic          act_q, act_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          line_done_q, line_done_d;
  logic          overrun_q, overrun_d;

  logic          zc_event, fire, swap, load;
  logic [LW-1:0] adv_line;
  logic [FW-1:0] adv_frame;
  logic [MW-1:0] adv_cycle;
  logic          adv_wrap;
  logic [CW-1:0] rd_col;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          wr_en;
  logic [16:0]   rdata_q;
  logic [16:0]   mem [2*DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wdata_i;
    rdata_q <= mem[rd_addr];
  end

  always_comb begin
    wr_en   = we_i && (int'(waddr_i) < FRAME_COLUMNS_P) && (int'(mem_select_i) < FRAME_NUMBER_P);
    wr_addr = AW'(int'(~active_bank_q) * DEPTH + int'(mem_select_i) * FRAME_COLUMNS_P + int'(waddr_i));
    // While playing, keep the entry after the current column staged in rdata_q.
    rd_col  = '0;
    if (state_q == PLAY && col_q != CW'(FRAME_COLUMNS_P - 1)) rd_col = col_q + CW'(1);
    rd_addr = AW'(int'(active_bank_q) * DEPTH + int'(frame_q) * FRAME_COLUMNS_P + int'(rd_col));
  end

  always_comb begin
    adv_line  = line_q + LW'(1);
    adv_frame = frame_q;
    adv_cycle = cycle_q;
    adv_wrap  = 1'b0;
    if (adv_line == LW'(FRAME_LINES_P)) begin
      adv_line  = '0;
      adv_frame = frame_q + FW'(1);
      if (adv_frame == FW'(FRAME_NUMBER_P)) begin
        adv_frame = '0;
        adv_cycle = cycle_q + MW'(1);
        if (adv_cycle == MW'(MEM_CYCLES_P)) begin
          adv_cycle = '0;
          adv_wrap  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    zc_meta_d   = zc_i;
    zc_sync_d   = zc_meta_q;
    zc_prev_d   = zc_sync_q;
    zc_event    = zc_sync_q & ~zc_prev_q;
    state_d     = state_q;
    frame_d     = frame_q;
    line_d      = line_q;
    col_d       = col_q;
    cycle_d     = cycle_q;
    delay_d     = delay_q;
    tick_d      = tick_q;
    act_d       = act_q;
    line_done_d = 1'b0;
    overrun_d   = 1'b0;
    fire        = 1'b0;
    swap        = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (shadow_valid_q) begin
          swap    = 1'b1;
          state_d = WAIT_ZC;
        end
      end
      WAIT_ZC: begin
        if (zc_event) begin
          col_d = '0;
          if (quarter_delay_i == '0) begin
            load    = 1'b1;
            state_d = PLAY;
          end else begin
            delay_d = quarter_delay_i;
            state_d = DELAY;
          end
        end
      end
      DELAY, PLAY: begin
        if (zc_event) begin
          // Abandon the line but account for it so the frame sequence stays aligned.
          overrun_d = 1'b1;
          line_d    = adv_line;
          frame_d   = adv_frame;
          cycle_d   = adv_cycle;
          swap      = adv_wrap & shadow_valid_q;
          col_d     = '0;
          delay_d   = quarter_delay_i;
          state_d   = DELAY;
        end else if (state_q == DELAY) begin
          if (delay_q <= 16'd1) begin
            load    = 1'b1;
            state_d = PLAY;
          end else begin
            delay_d = delay_q - 16'd1;
          end
        end else if (tick_q == 16'd1) begin
          fire = 1'b1;
          if (col_q == CW'(FRAME_COLUMNS_P - 1)) begin
            line_done_d = 1'b1;
            col_d       = '0;
            state_d     = LINE_END;
          end else begin
            col_d = col_q + CW'(1);
            load  = 1'b1;
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      LINE_END: begin
        line_d  = adv_line;
        frame_d = adv_frame;
        cycle_d = adv_cycle;
        swap    = adv_wrap & shadow_valid_q;
        state_d = WAIT_ZC;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tick_d = (rdata_q[15:0] < 16'd2) ? 16'd2 : rdata_q[15:0];
      act_d  = rdata_q[16];
    end

    pulse_d = pulse_q;
    if (fire && act_q)        pulse_d = PW'(PULSE_LENGTH_P);
    else if (pulse_q != '0)   pulse_d = pulse_q - PW'(1);

    active_bank_d  = swap ? ~active_bank_q : active_bank_q;
    update_mem_d   = swap ? ~update_mem_q : update_mem_q;
    shadow_valid_d = (shadow_valid_q & ~swap) | bank_done_i;
  end

`ifdef LASER_TICK_PLAYER_STATS_EN
  logic [31:0] pulses_q, pulses_d;

  always_comb begin
    pulses_d = pulses_q;
    if (swap)                                     pulses_d = '0;
    else if (fire && act_q && pulses_q != '1)     pulses_d = pulses_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pulses_q <= '0;
    else       pulses_q <= pulses_d;
  end

  assign pulses_fired_o = pulses_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      zc_meta_q      <= 1'b0;
      zc_sync_q      <= 1'b0;
      zc_prev_q      <= 1'b0;
      active_bank_q  <= 1'b0;
      shadow_valid_q <= 1'b0;
      update_mem_q   <= 1'b0;
      frame_q        <= '0;
      line_q         <= '0;
      col_q          <= '0;
      cycle_q        <= '0;
      delay_q        <= '0;
      tick_q         <= '0;
      act_q          <= 1'b0;
      pulse_q        <= '0;
      line_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      zc_meta_q      <= zc_meta_d;
      zc_sync_q      <= zc_sync_d;
      zc_prev_q      <= zc_prev_d;
      active_bank_q  <= active_bank_d;
      shadow_valid_q <= shadow_valid_d;
      update_mem_q   <= update_mem_d;
      frame_q        <= frame_d;
      line_q         <= line_d;
      col_q          <= col_d;
      cycle_q        <= cycle_d;
      delay_q        <= delay_d;
      tick_q         <= tick_d;
      act_q          <= act_d;
      pulse_q        <= pulse_d;
      line_done_q    <= line_done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign laser_trigger_o  = (pulse_q != '0);
  assign update_mem_o     = update_mem_q;
  assign line_completed_o = line_done_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_laser_tick_player.sv
// tb/tb_laser_tick_player.sv - directed bench for laser_tick_player
// Small geometry: 4 columns, 2 lines, 2 frames, 1 memory cycle, 3-cycle pulses.
module tb_laser_tick_player;

  logic        clk = 1'b0;
  logic        rst_i, zc_i, we_i, bank_done_i;
  logic [10:0] waddr_i;
  logic [16:0] wdata_i;
  logic [2:0]  mem_select_i;
  logic [15:0] quarter_delay_i;
  logic        laser_trigger_o, update_mem_o, line_completed_o, overrun_o;
`ifdef LASER_TICK_PLAYER_STATS_EN
  logic [31:0] pulses_fired;
`endif

  laser_tick_player #(
    .FRAME_COLUMNS_P(4),
    .FRAME_LINES_P  (2),
    .FRAME_NUMBER_P (2),
    .MEM_CYCLES_P   (1),
    .PULSE_LENGTH_P (3)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .zc_i            (zc_i),
    .waddr_i         (waddr_i),
    .wdata_i         (wdata_i),
    .we_i            (we_i),
    .mem_select_i    (mem_select_i),
    .bank_done_i     (bank_done_i),
    .quarter_delay_i (quarter_delay_i),
    .laser_trigger_o (laser_trigger_o),
    .update_mem_o    (update_mem_o),
    .line_completed_o(line_completed_o),
    .overrun_o       (overrun_o)
`ifdef LASER_TICK_PLAYER_STATS_EN
    ,
    .pulses_fired_o  (pulses_fired)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rises[$];
  int lcs[$];
  int ovs[$];
  int ums[$];
  int high_cnt = 0;
  logic laser_prev = 1'b0;
  logic um_prev = 1'b0;

  always @(negedge clk) begin
    if (laser_trigger_o && !laser_prev) rises.push_back(cyc);
    if (laser_trigger_o) high_cnt++;
    if (line_completed_o) lcs.push_back(cyc);
    if (overrun_o) ovs.push_back(cyc);
    if (update_mem_o !== um_prev) ums.push_back(cyc);
    laser_prev = laser_trigger_o;
    um_prev    = update_mem_o;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int within1(input int v, input int nom);
    if (v >= nom - 1 && v <= nom + 1) return nom;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ms, input int wa, input int dt, input bit act);
    mem_select_i = 3'(ms);
    waddr_i      = 11'(wa);
    wdata_i      = {act, 16'(dt)};
    we_i         = 1'b1;
    tick(1);
    we_i         = 1'b0;
  endtask

  task automatic clear_log();
    rises.delete();
    lcs.delete();
    ovs.delete();
    ums.delete();
    high_cnt = 0;
  endtask

  task automatic run_line(input int n, output int z);
    clear_log();
    zc_i = 1'b1;
    z    = cyc;
    tick(4);
    zc_i = 1'b0;
    tick(n - 4);
  endtask

  int f1_dt[4]  = '{1, 0, 6, 6};
  bit f1_act[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int z, z1, z2, n;

  initial begin
    rst_i = 1'b1; zc_i = 1'b0; we_i = 1'b0; bank_done_i = 1'b0;
    waddr_i = '0; wdata_i = '0; mem_select_i = '0; quarter_delay_i = 16'd20;
    tick(3);
    check_eq("reset laser", int'(laser_trigger_o), 0);
    check_eq("reset update_mem", int'(update_mem_o), 0);
    check_eq("reset line_completed", int'(line_completed_o), 0);
    check_eq("reset overrun", int'(overrun_o), 0);
    rst_i = 1'b0;
    tick(2);
    check_eq("idle without bank_done", int'(update_mem_o), 0);

    for (int c = 0; c < 4; c++) wr(0, c, 10, 1'b1);
    for (int c = 0; c < 4; c++) wr(1, c, f1_dt[c], f1_act[c]);
    clear_log();
    bank_done_i = 1'b1;
    tick(1);
    bank_done_i = 1'b0;
    tick(1);
    check_eq("initial swap update_mem", int'(update_mem_o), 1);
    tick(10);
    check_eq("no pulse before zc", rises.size(), 0);
    check_eq("single initial toggle", ums.size(), 1);

    // Line A: frame 0, dt=10 everywhere
    run_line(70, z);
    check_eq("lineA rises", rises.size(), 4);
    check_eq("lineA first fire offset", within1(q_at(rises, 0) - z, 33), 33);
    check_eq("lineA spacing 1", q_at(rises, 1) - q_at(rises, 0), 10);
    check_eq("lineA spacing 2", q_at(rises, 2) - q_at(rises, 1), 10);
    check_eq("lineA spacing 3", q_at(rises, 3) - q_at(rises, 2), 10);
    check_eq("lineA high cycles", high_cnt, 12);
    check_eq("lineA line_completed count", lcs.size(), 1);
    check_eq("lineA line_completed on last fire", q_at(lcs, 0), q_at(rises, 3));
    check_eq("lineA no overrun", ovs.size(), 0);

    // Line B aborted 15 cycles into play, then line C plays frame 1
    clear_log();
    zc_i = 1'b1; z1 = cyc; tick(4); zc_i = 1'b0;
    tick(34);
    check_eq("lineB fires before abort", rises.size(), 1);
    clear_log();
    zc_i = 1'b1; z2 = cyc; tick(4); zc_i = 1'b0;
    tick(46);
    check_eq("overrun count", ovs.size(), 1);
    check_eq("overrun latency", within1(q_at(ovs, 0) - z2, 3), 3);
    check_eq("lineC rises", rises.size(), 2);
    check_eq("lineC first fire offset", within1(q_at(rises, 0) - z2, 25), 25);
    check_eq("lineC slot after inactive", q_at(rises, 1) - q_at(rises, 0), 14);
    check_eq("lineC retrigger high cycles", high_cnt, 8);
    check_eq("lineC line_completed count", lcs.size(), 1);
    check_eq("lineC line_completed on last fire", q_at(lcs, 0), q_at(rises, 1));

    // New bank contents plus out-of-range writes that must be dropped
    for (int c = 0; c < 4; c++) begin
      wr(0, c, 5, 1'b1);
      wr(1, c, 5, 1'b1);
    end
    wr(0, 4, 2, 1'b1);
    wr(4, 0, 2, 1'b1);

    // Line D: last line of the pass, bank_done mid-play
    clear_log();
    zc_i = 1'b1; z = cyc; tick(4); zc_i = 1'b0;
    tick(22);
    bank_done_i = 1'b1; tick(1); bank_done_i = 1'b0;
    tick(23);
    check_eq("lineD old bank rises", rises.size(), 2);
    check_eq("lineD toggle count", ums.size(), 1);
    check_eq("lineD toggle at line end", q_at(ums, 0) - q_at(lcs, 0), 1);
    check_eq("lineD update_mem", int'(update_mem_o), 0);

    run_line(50, z);
    check_eq("lineE rises", rises.size(), 4);
    check_eq("lineE new bank first fire", within1(q_at(rises, 0) - z, 28), 28);
    check_eq("lineE spacing", q_at(rises, 3) - q_at(rises, 2), 5);
    check_eq("lineE high cycles", high_cnt, 12);
    run_line(50, z);
    check_eq("lineF line_completed", lcs.size(), 1);
    run_line(50, z);
    check_eq("lineG rises", rises.size(), 4);
    check_eq("lineG frame1 col0 intact", within1(q_at(rises, 0) - z, 28), 28);
    run_line(50, z);
    check_eq("lineH line_completed", lcs.size(), 1);
    check_eq("no swap without bank_done", ums.size(), 0);
    check_eq("update_mem held", int'(update_mem_o), 0);

    // Line I replays the same bank; reset lands during the first pulse
    clear_log();
    zc_i = 1'b1; z = cyc; tick(4); zc_i = 1'b0;
    n = 0;
    while (rises.size() == 0 && n < 40) begin
      tick(1);
      n++;
    end
    check_eq("lineI fire seen", rises.size(), 1);
    check_eq("lineI replay first fire", within1(q_at(rises, 0) - z, 28), 28);
    check_eq("laser high before reset", int'(laser_trigger_o), 1);
    rst_i = 1'b1;
    tick(1);
    check_eq("laser dropped by reset", int'(laser_trigger_o), 0);
    check_eq("update_mem cleared by reset", int'(update_mem_o), 0);
    rst_i = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
